// File: rtl/mb_loop_sched_pkg.sv
// Fixed-point number and ray message types shared by the Mandelbulb loop scheduler.
package fixedpoint;

    localparam int FP_W        = 16;
    localparam int ITER_W      = 8;
    localparam int MB_MAX_ITER = 8;

    typedef logic signed [FP_W-1:0] fixed_t;

    typedef struct packed {
        logic [15:0]       ray_id;
        fixed_t            x;
        fixed_t            y;
        fixed_t            z;
        logic [ITER_W-1:0] mb_iter;
        logic              threshold;
    } message;

    // A fresh ray starts at iteration zero with its escape flag clear.
    function automatic message issue_new(input message m);
        message r;
        r           = m;
        r.mb_iter   = '0;
        r.threshold = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mb_done_fifo.sv
// First-word-fall-through FIFO of completed rays with an occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module mb_done_fifo #(
    parameter int  DEPTH = 16,
    parameter int  CNT_W = 6,
    parameter type T     = fixedpoint::message
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_msg,
    input  logic             pop,
    output T                 head_msg,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign empty    = (count == '0);
    assign head_msg = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_msg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mb_loop_sched.sv
// Issues new and recirculating rays into the iteration pipeline and collects finished rays.
// Credits cap rays in flight plus queued results at DONE_DEPTH, so the done FIFO never overflows.
module mb_loop_sched
    import fixedpoint::*;
#(
    parameter int MAX_ITER   = MB_MAX_ITER,
    parameter int DONE_DEPTH = 16,
    parameter int CNT_W      = 6
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  message in_msg,
    output logic   in_ready,
    output logic   pipe_valid,
    output message pipe_msg,
    input  logic   ret_valid,
    input  message ret_msg,
    output logic   done_valid,
    output message done_msg,
    input  logic   done_ready,
    output logic   idle
);

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
    localparam logic [CNT_W:0]    CREDITS   = (CNT_W+1)'(DONE_DEPTH);

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_nxt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;
    logic             fin_cond;
    logic             ret_ok;
    logic             fin;
    logic             recirc;
    logic             accept;
    logic             pop;
    logic             fifo_empty;

    assign fin_cond = ret_msg.threshold || (ret_msg.mb_iter >= LAST_ITER);
    // A return with nothing in flight is a stale or bogus message; drop it.
    assign ret_ok   = ret_valid && (inflight != '0);
    assign fin      = ret_ok && fin_cond;
    assign recirc   = ret_ok && !fin_cond;

    assign in_ready = !rst && !(ret_valid && !fin_cond)
                      && (({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS);
    assign accept   = in_valid && in_ready;

    assign done_valid = !fifo_empty;
    assign pop        = done_valid && done_ready;

    always_comb begin
        inflight_nxt = inflight;
        if (accept && !fin)
            inflight_nxt = inflight + CNT_W'(1);
        else if (fin && !accept)
            inflight_nxt = inflight - CNT_W'(1);
        count_nxt = fifo_count;
        if (fin && !pop)
            count_nxt = fifo_count + CNT_W'(1);
        else if (pop && !fin)
            count_nxt = fifo_count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_msg   <= '0;
            inflight   <= '0;
            idle       <= 1'b0;
        end else begin
            pipe_valid <= recirc || accept;
            if (recirc) begin
                pipe_msg         <= ret_msg;
                pipe_msg.mb_iter <= ret_msg.mb_iter + ITER_W'(1);
            end else if (accept) begin
                pipe_msg <= issue_new(in_msg);
            end
            inflight <= inflight_nxt;
            idle     <= (inflight_nxt == '0) && (count_nxt == '0);
        end
    end

    mb_done_fifo #(
        .DEPTH (DONE_DEPTH),
        .CNT_W (CNT_W),
        .T     (message)
    ) u_done_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fin),
        .push_msg (ret_msg),
        .pop      (pop),
        .head_msg (done_msg),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
